// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard/stall inputs and pipeline enable/flush controls
// shared between the datapath (master) and the pipeline controller (slave).
`timescale 1ns/1ps

interface pipe_ctrl_if;
   // Hazard and stall conditions presented by the datapath
   logic icache_stall;
   logic dcache_stall;
   logic load_use;
   logic branch_taken;
   logic mul_start;

   // Pipeline register enables
   logic pc_en;
   logic fd_en;
   logic de_en;
   logic em_en;
   logic mw_en;

   // Bubble-insert clears; a flush overrides the matching enable
   logic fd_flush;
   logic de_flush;
   logic em_flush;
   logic mw_flush;

   // Multiply result valid in E
   logic mul_done;

   // Datapath side: raises hazards, consumes controls
   modport master (
      output icache_stall, dcache_stall, load_use, branch_taken, mul_start,
      input  pc_en, fd_en, de_en, em_en, mw_en,
      input  fd_flush, de_flush, em_flush, mw_flush,
      input  mul_done
   );

   // Controller side: consumes hazards, drives controls
   modport slave (
      input  icache_stall, dcache_stall, load_use, branch_taken, mul_start,
      output pc_en, fd_en, de_en, em_en, mw_en,
      output fd_flush, de_flush, em_flush, mw_flush,
      output mul_done
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- five-stage pipeline stall/flush controller with a multi-cycle
// multiply hold in E.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters as extra output ports.
// MUL_LATENCY must lie in 2..15 so the latency fits the 4-bit counter.
`timescale 1ns/1ps

module pipe_ctrl #(
   parameter int MUL_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

   state_t     state_reg;
   logic [3:0] cnt_reg;

   logic e_busy;
   logic mul_last;
   logic branch_flush;

   logic pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c;
   logic fd_flush_c, de_flush_c, em_flush_c, mw_flush_c;
   logic mul_done_c;

   // Final countdown cycle of a multiply: result valid, E released this cycle
   assign mul_last = (state_reg == MUL_WAIT) && (cnt_reg == 4'd1);

   // E is held either by a multiply still counting down or by one just arriving
   assign e_busy = ((state_reg == MUL_WAIT) && (cnt_reg != 4'd1)) ||
                   ((state_reg == RUN) && bus.mul_start);

   // Priority resolution of stall/flush controls; reset forces a full freeze
   always_comb begin
      pc_en_c      = 1'b1;
      fd_en_c      = 1'b1;
      de_en_c      = 1'b1;
      em_en_c      = 1'b1;
      mw_en_c      = 1'b1;
      fd_flush_c   = 1'b0;
      de_flush_c   = 1'b0;
      em_flush_c   = 1'b0;
      mw_flush_c   = 1'b0;
      mul_done_c   = 1'b0;
      branch_flush = 1'b0;

      if (!reset_n) begin
         pc_en_c    = 1'b0;
         fd_en_c    = 1'b0;
         de_en_c    = 1'b0;
         em_en_c    = 1'b0;
         mw_en_c    = 1'b0;
         fd_flush_c = 1'b1;
         de_flush_c = 1'b1;
         em_flush_c = 1'b1;
         mw_flush_c = 1'b1;
      end else begin
         // The done pulse is independent of any freeze in the same cycle
         mul_done_c = mul_last;

         if (bus.dcache_stall) begin
            // M cannot retire: freeze everything up to M, drain a bubble into W
            pc_en_c    = 1'b0;
            fd_en_c    = 1'b0;
            de_en_c    = 1'b0;
            em_en_c    = 1'b0;
            mw_flush_c = 1'b1;
         end else if (e_busy) begin
            // E occupied by the multiply: hold front end, bubble into M
            pc_en_c    = 1'b0;
            fd_en_c    = 1'b0;
            de_en_c    = 1'b0;
            em_flush_c = 1'b1;
         end else if (bus.branch_taken) begin
            // Redirect: squash the two younger instructions, fetch the target
            fd_flush_c   = 1'b1;
            de_flush_c   = 1'b1;
            branch_flush = 1'b1;
         end else if (bus.load_use) begin
            // Keep the dependent instruction in D, bubble into E
            pc_en_c    = 1'b0;
            fd_en_c    = 1'b0;
            de_flush_c = 1'b1;
         end else if (bus.icache_stall) begin
            // No instruction fetched: hold PC, bubble into D
            pc_en_c    = 1'b0;
            fd_flush_c = 1'b1;
         end
      end
   end

   assign bus.pc_en    = pc_en_c;
   assign bus.fd_en    = fd_en_c;
   assign bus.de_en    = de_en_c;
   assign bus.em_en    = em_en_c;
   assign bus.mw_en    = mw_en_c;
   assign bus.fd_flush = fd_flush_c;
   assign bus.de_flush = de_flush_c;
   assign bus.em_flush = em_flush_c;
   assign bus.mw_flush = mw_flush_c;
   assign bus.mul_done = mul_done_c;

   // Multiply FSM: accept when not frozen by M, count down regardless of stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= RUN;
         cnt_reg   <= 4'd0;
      end else begin
         case (state_reg)
            RUN: begin
               if (bus.mul_start && !bus.dcache_stall) begin
                  state_reg <= MUL_WAIT;
                  cnt_reg   <= CNT_LOAD;
               end
            end
            MUL_WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= RUN;
               end
            end
            default: begin
               state_reg <= RUN;
               cnt_reg   <= 4'd0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_reg;
   logic [15:0] flush_count_reg;

   // Count PC-hold cycles and taken-branch redirects; both wrap naturally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_reg <= 32'd0;
         flush_count_reg  <= 16'd0;
      end else begin
         if (!pc_en_c) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
         if (branch_flush) begin
            flush_count_reg <= flush_count_reg + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl. The stimulus process pushes
// the expected controls for each cycle; a monitor pops and compares them on
// the falling edge. Build with PIPE_CTRL_PERF_EN to also check the counters.
`timescale 1ns/1ps

module tb_pipe_ctrl;
   localparam int LAT = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   pipe_ctrl #(.MUL_LATENCY(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  ctl;   // {pc,fd,de,em,mw en, fd,de,em,mw flush, mul_done}
      int unsigned stall;
      int unsigned flush;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 0;

   // Reference model: the multiply is tracked as an absolute release cycle
   bit          m_in_mul  = 0;
   int          m_release = 0;
   int          cyc       = 0;
   int unsigned m_stall   = 0;
   int unsigned m_flush   = 0;

   task automatic model_reset();
      m_in_mul = 0;
      m_stall  = 0;
      m_flush  = 0;
   endtask

   // One clock cycle of stimulus; pulse=1 glitches reset between edges first
   task automatic step(input bit rst, input bit ic, input bit dc, input bit lu,
                       input bit br, input bit ms, input string tag,
                       input bit pulse = 0);
      exp_t e;
      bit pc, fd, de, em, mw, ffd, fde, fem, fmw, done, busy, brf;
      @(posedge clk);
      #1;
      if (pulse) begin
         reset_n = 1'b0;
         #1;
         reset_n = 1'b1;
         #1;
         model_reset();
      end
      reset_n          = rst;
      bus.icache_stall = ic;
      bus.dcache_stall = dc;
      bus.load_use     = lu;
      bus.branch_taken = br;
      bus.mul_start    = ms;

      if (!rst) model_reset();

      pc = 1; fd = 1; de = 1; em = 1; mw = 1;
      ffd = 0; fde = 0; fem = 0; fmw = 0; done = 0; brf = 0;
      busy = m_in_mul ? (cyc < m_release) : ms;
      if (!rst) begin
         {pc, fd, de, em, mw} = 5'b0;
         {ffd, fde, fem, fmw} = 4'hF;
      end else begin
         done = m_in_mul && (cyc == m_release);
         if (dc) begin
            {pc, fd, de, em} = 4'b0;
            fmw = 1;
         end else if (busy) begin
            {pc, fd, de} = 3'b0;
            fem = 1;
         end else if (br) begin
            ffd = 1; fde = 1; brf = 1;
         end else if (lu) begin
            pc = 0; fd = 0; fde = 1;
         end else if (ic) begin
            pc = 0; ffd = 1;
         end
      end
      e.ctl   = {pc, fd, de, em, mw, ffd, fde, fem, fmw, done};
      e.stall = m_stall;
      e.flush = m_flush;
      e.tag   = tag;
      q.push_back(e);

      // Advance model to the next cycle
      if (rst) begin
         if (!pc) m_stall++;
         if (brf) m_flush = (m_flush + 1) & 32'hFFFF;
         if (m_in_mul && cyc == m_release) begin
            m_in_mul = 0;
         end else if (!m_in_mul && ms && !dc) begin
            m_in_mul  = 1;
            m_release = cyc + LAT - 1;
         end
      end
      cyc++;
   endtask

   // Monitor: compare DUT controls against the scoreboard head
   initial begin
      exp_t e;
      logic [9:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.pc_en, bus.fd_en, bus.de_en, bus.em_en, bus.mw_en,
                   bus.fd_flush, bus.de_flush, bus.em_flush, bus.mw_flush,
                   bus.mul_done};
            checks++;
            if (act !== e.ctl) begin
               errors++;
               $display("FAIL ctl[%s] t=%0t got=%b want=%b", e.tag, $time, act, e.ctl);
            end else begin
               $display("ok   ctl[%s] t=%0t ctl=%b", e.tag, $time, act);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (stall_cycles !== e.stall) begin
               errors++;
               $display("FAIL stall_cycles[%s] got=%0d want=%0d", e.tag, stall_cycles, e.stall);
            end
            checks++;
            if (flush_count !== 16'(e.flush)) begin
               errors++;
               $display("FAIL flush_count[%s] got=%0d want=%0d", e.tag, flush_count, e.flush);
            end
`endif
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bus.icache_stall = 0;
      bus.dcache_stall = 0;
      bus.load_use     = 0;
      bus.branch_taken = 0;
      bus.mul_start    = 0;

      // Reset hold, then release
      repeat (3) step(0, 0, 0, 0, 0, 0, "reset");
      repeat (2) step(1, 0, 0, 0, 0, 0, "idle");

      // Plain multiply: E held three cycles, done on the fourth
      step(1, 0, 0, 0, 0, 1, "mul_start");
      repeat (5) step(1, 0, 0, 0, 0, 0, "mul_wait");

      // Multiply with M stalled across the done cycle
      step(1, 0, 0, 0, 0, 1, "mul_dc_start");
      repeat (5) step(1, 0, 1, 0, 0, 0, "mul_dc_stall");
      repeat (2) step(1, 0, 0, 0, 0, 0, "mul_dc_after");

      // Back-to-back multiplies: new start right after done
      step(1, 0, 0, 0, 0, 1, "b2b_a");
      repeat (3) step(1, 0, 0, 0, 0, 0, "b2b_wait");
      step(1, 0, 0, 0, 0, 1, "b2b_b");
      repeat (4) step(1, 0, 0, 0, 0, 0, "b2b_wait2");

      // Priority corners
      step(1, 1, 0, 1, 1, 0, "br_lu_ic");
      step(1, 0, 1, 0, 1, 0, "dc_br");
      step(1, 0, 0, 1, 0, 0, "load_use");
      step(1, 1, 0, 0, 0, 0, "icache");

      // Reset while cnt=2 in MUL_WAIT, three cycles low, then idle
      step(1, 0, 0, 0, 0, 1, "rst_mul_start");
      step(1, 0, 0, 0, 0, 0, "rst_cnt3");
      repeat (3) step(0, 0, 0, 0, 0, 0, "rst_mid_mul");
      repeat (4) step(1, 0, 0, 0, 0, 0, "rst_after");

      // Reset glitch between edges abandons the multiply
      step(1, 0, 0, 0, 0, 1, "glitch_start");
      step(1, 0, 0, 0, 0, 0, "glitch", 1);
      repeat (3) step(1, 0, 0, 0, 0, 0, "glitch_after");

      // Counter scenario: 5 fetch stalls and 2 branch flushes after reset
      step(0, 0, 0, 0, 0, 0, "perf_rst");
      repeat (5) step(1, 1, 0, 0, 0, 0, "perf_ic");
      repeat (2) step(1, 0, 0, 0, 1, 0, "perf_br");
      repeat (2) step(1, 0, 0, 0, 0, 0, "perf_idle");

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(99) >= 2),
              ($urandom_range(99) < 25),
              ($urandom_range(99) < 15),
              ($urandom_range(99) < 20),
              ($urandom_range(99) < 15),
              ($urandom_range(99) < 15),
              "rand");
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end
      stim_done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 4: cycles a multiply occupies E; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 icache_stall  input  1  fetch miss; instruction not available in F.
REQ-005 dcache_stall  input  1  memory-stage miss; M cannot complete.
REQ-006 load_use  input  1  hazard unit: D depends on a load currently in E.
REQ-007 branch_taken  input  1  E resolved a taken branch or jump this cycle.
REQ-008 mul_start  input  1  a multiply instruction is in E.
REQ-009 pc_en, fd_en, de_en, em_en, mw_en  output  1 each  enables for the PC and the F/D, D/E, E/M, M/W pipeline registers.
REQ-010 fd_flush, de_flush, em_flush, mw_flush  output  1 each  synchronous clear (bubble insert) for those registers; a flush overrides its enable.
REQ-011 mul_done  output  1  one-cycle pulse when the multiply result is valid in E.

Function
REQ-012 The FSM SHALL have exactly two states, RUN and MUL_WAIT, plus a 4-bit down-counter cnt.
REQ-013 Control outputs SHALL be combinational from the current inputs and state. Priority is highest first; default is every en=1 and every flush=0.
REQ-014 dcache_stall: pc_en=fd_en=de_en=em_en=0, mw_en=1, mw_flush=1.
REQ-015 Otherwise, E busy (MUL_WAIT with cnt!=1, or RUN with mul_start): pc_en=fd_en=de_en=0, em_flush=1.
REQ-016 Otherwise, branch_taken: all en=1, fd_flush=de_flush=1; this overrides load_use and icache_stall.
REQ-017 Otherwise, load_use: pc_en=fd_en=0, de_flush=1.
REQ-018 Otherwise, icache_stall: pc_en=0, fd_flush=1.
REQ-019 In RUN, mul_start with dcache_stall low SHALL move the FSM to MUL_WAIT and load cnt=MUL_LATENCY-1. With dcache_stall high, mul_start is ignored that cycle.
REQ-020 In MUL_WAIT, cnt SHALL decrement every cycle, including cycles in which dcache_stall is high.
REQ-021 In MUL_WAIT with cnt==1, mul_done SHALL be 1, the E stall SHALL release, and the FSM SHALL return to RUN. Result: a multiply accepted at cycle t holds E for cycles t..t+MUL_LATENCY-2 and releases at t+MUL_LATENCY-1.
REQ-022 If dcache_stall is high in the mul_done cycle, mul_done SHALL still pulse and the freeze SHALL follow REQ-014.
REQ-023 mul_start in RUN in the cycle immediately after mul_done SHALL start a new multiply.

Reset
REQ-024 reset_n low SHALL immediately force state RUN and cnt=0, independent of clk.
REQ-025 While reset_n is low: all en=0, all flush=1, mul_done=0.
REQ-026 Reset asserted during MUL_WAIT SHALL abandon the multiply, with no mul_done pulse.
REQ-027 The first rising edge after reset_n deasserts SHALL see the REQ-013 outputs.

Configuration
REQ-028 With macro PIPE_CTRL_PERF_EN defined, the module SHALL add two outputs:
- stall_cycles (32-bit): +1 per cycle with pc_en=0 and reset_n high; wraps at 2^32.
- flush_count (16-bit): +1 per REQ-016 branch flush; wraps at 2^16.
- Both clear on reset.
REQ-029 With PIPE_CTRL_PERF_EN undefined, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 MUL_LATENCY=4; mul_start at cycle 10 → em_flush=1 in cycles 10-12; mul_done=1 and all en=1 in cycle 13.
REQ-031 MUL_LATENCY=4; mul_start at cycle 10, dcache_stall in cycles 11-15 → mul_done at 13 with freeze; em_en=1 at 16.
REQ-032 branch_taken=load_use=icache_stall=1 together → fd_flush=de_flush=1, pc_en=1.
REQ-033 dcache_stall and branch_taken together → pc_en=0, mw_flush=1, fd_flush=0.
REQ-034 reset_n low at cnt=2 in MUL_WAIT, released 3 cycles later, with mul_start=0 → state RUN, no mul_done, all en=1.
REQ-035 PIPE_CTRL_PERF_EN: 5 icache_stall cycles plus 2 branch flushes → stall_cycles=5, flush_count=2.
